// File: rtl/uart_tx_byte_serializer.sv
// uart_tx_byte_serializer: byte-to-UART serializer, 8N1 frame, LSB first.
// Sits downstream of the 128-bit message shifter; byte_done is the shifter's
// advance strobe. Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_byte_serializer #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       byte_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shreg_q, shreg_d;
  logic                tx_serial_q, tx_serial_d;
  logic                tx_ready_q, tx_ready_d;
  logic                tx_busy_q, tx_busy_d;
  logic                byte_done_q, byte_done_d;
  logic                baud_wrap_c;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  assign baud_wrap_c = (baud_q == BAUD_LAST);

  // State register and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      tx_serial_q <= 1'b1;
      tx_ready_q  <= 1'b1;
      tx_busy_q   <= 1'b0;
      byte_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      tx_serial_q <= tx_serial_d;
      tx_ready_q  <= tx_ready_d;
      tx_busy_q   <= tx_busy_d;
      byte_done_q <= byte_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // Next-state, baud/bit counters, shift register and next output values.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    tx_serial_d = 1'b1;
    tx_ready_d  = 1'b0;
    tx_busy_d   = 1'b0;
    byte_done_d = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    // Baud counter wraps exactly at each bit boundary so bits never drift.
    if (state_q != S_IDLE) begin
      baud_d = baud_wrap_c ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        baud_d    = '0;
        bit_cnt_d = '0;
        if (tx_valid) begin
          shreg_d = tx_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_wrap_c) begin
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_wrap_c) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_wrap_c) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_wrap_c) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Line level follows the state being entered, so it is a clean flop output.
    case (state_d)
      S_START: tx_serial_d = 1'b0;
      S_DATA:  tx_serial_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_serial_d = parity_d;
`endif
      default: tx_serial_d = 1'b1;
    endcase

    tx_ready_d  = (state_d == S_IDLE);
    tx_busy_d   = (state_d != S_IDLE);
    byte_done_d = (state_q == S_STOP) && (state_d == S_IDLE);
  end

  assign tx_serial = tx_serial_q;
  assign tx_ready  = tx_ready_q;
  assign tx_busy   = tx_busy_q;
  assign byte_done = byte_done_q;

endmodule

// File: tb/tb_uart_tx_byte_serializer.sv
// Testbench for uart_tx_byte_serializer with CLKS_PER_BIT=4.
// Honours UART_TX_PARITY_EN for the expected frame length and parity slot.
module tb_uart_tx_byte_serializer;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk;
  logic       nrst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_busy;
  logic       byte_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  uart_tx_byte_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .byte_done (byte_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one byte for a single accept cycle; returns just after the accept edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  // Observe a frame starting just after its accept edge. Optionally raise
  // tx_valid with new_data at cycle inject_at. Returns just after the edge
  // following the byte_done cycle.
  task automatic watch_frame(input logic [7:0] b, input string nm,
                             input int inject_at, input logic [7:0] new_data);
    logic [NBITS-1:0] exp_bits;
    logic [NBITS-1:0] got;
    int early_done;
    exp_bits = '1;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    exp_bits[9] = ^b;
`endif
    got = '0;
    early_done = 0;
    total_cnt++;
    if ({tx_busy, tx_ready} !== 2'b10) begin
      $display("FAIL %s accept: busy/ready=%b expected 10", nm, {tx_busy, tx_ready});
    end else pass_cnt++;
    for (int c = 0; c < FRAME; c++) begin
      if (c == inject_at) begin
        tx_data  = new_data;
        tx_valid = 1'b1;
      end
      if ((c % CPB) == (CPB / 2)) got[c / CPB] = tx_serial;
      if (byte_done !== 1'b0) early_done++;
      @(posedge clk);
      #1;
    end
    total_cnt++;
    if (got !== exp_bits) begin
      $display("FAIL %s frame: got %b expected %b (slot0 at right)", nm, got, exp_bits);
    end else pass_cnt++;
    total_cnt++;
    if (early_done != 0) begin
      $display("FAIL %s early_done: %0d early byte_done cycles, expected 0", nm, early_done);
    end else pass_cnt++;
    total_cnt++;
    if ({byte_done, tx_ready, tx_busy} !== 3'b110) begin
      $display("FAIL %s done: done/ready/busy=%b expected 110", nm,
               {byte_done, tx_ready, tx_busy});
    end else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (byte_done !== 1'b0) begin
      $display("FAIL %s done_width: byte_done=%b expected 0", nm, byte_done);
    end else pass_cnt++;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({tx_serial, tx_ready, tx_busy, byte_done} !== 4'b1100) begin
      $display("FAIL reset: serial/ready/busy/done=%b expected 1100",
               {tx_serial, tx_ready, tx_busy, byte_done});
    end else pass_cnt++;
    nrst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({tx_serial, tx_ready, tx_busy, byte_done} !== 4'b1100) begin
      $display("FAIL idle: serial/ready/busy/done=%b expected 1100",
               {tx_serial, tx_ready, tx_busy, byte_done});
    end else pass_cnt++;
  endtask

  // 8'hA5 -> slots 0,1,0,1,0,0,1,0,1,1 (parity slot 0 when enabled).
  task automatic test_single();
    int edges;
    @(negedge clk);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    edges = 0;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    edges++;
    while (byte_done !== 1'b1 && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    total_cnt++;
    if (edges != FRAME + 1) begin
      $display("FAIL single latency: byte_done after %0d edges, expected %0d", edges, FRAME + 1);
    end else pass_cnt++;
    repeat (3) @(posedge clk);
    send_byte(8'hA5);
    watch_frame(8'hA5, "single_a5", -1, 8'h00);
    send_byte(8'h07);
    watch_frame(8'h07, "single_07", -1, 8'h00);
  endtask

  task automatic test_busy_ignore();
    send_byte(8'h3C);
    watch_frame(8'h3C, "busy_3c", 10, 8'hFF);
    tx_valid = 1'b0;
    watch_frame(8'hFF, "busy_ff", -1, 8'h00);
  endtask

  // tx_valid held high; second byte is taken in the byte_done cycle.
  task automatic test_back_to_back();
    @(negedge clk);
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_data = 8'h80;
    watch_frame(8'h01, "b2b_01", -1, 8'h00);
    tx_valid = 1'b0;
    watch_frame(8'h80, "b2b_80", -1, 8'h00);
  endtask

  task automatic test_reset_mid();
    int dones;
    send_byte(8'h5A);
    repeat (17) @(posedge clk);
    #1;
    nrst = 1'b0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    total_cnt++;
    if ({tx_serial, tx_ready, tx_busy} !== 3'b110) begin
      $display("FAIL reset_mid: serial/ready/busy=%b expected 110",
               {tx_serial, tx_ready, tx_busy});
    end else pass_cnt++;
    dones = 0;
    for (int c = 0; c < 60; c++) begin
      if (byte_done !== 1'b0 || tx_serial !== 1'b1) dones++;
      @(posedge clk);
      #1;
    end
    total_cnt++;
    if (dones != 0) begin
      $display("FAIL reset_mid quiet: %0d active cycles after abort, expected 0", dones);
    end else pass_cnt++;
    send_byte(8'hC3);
    watch_frame(8'hC3, "after_reset_c3", -1, 8'h00);
  endtask

  initial begin
    nrst     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    test_reset();
    test_single();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
